pipe_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and synchronous-clear inputs of the enable/clear pipeline flops: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Owns the multicycle divider start/wait handshake, so EX is held for the divider's fixed latency.
- Resolves priority between fetch stalls, load-use hazards, divider busy, data-memory stalls and exception flushes.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_stall_ctrl_if.sv | 26 ++
 rtl/pipe_stall_ctrl_div_seq.sv | 80 ++++++++
 rtl/pipe_stall_ctrl.sv | 65 ++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Divider handshake sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Stall level, ordered so a larger value means a deeper stall source
    localparam logic [2:0] LVL_NONE = 3'd0;
    localparam logic [2:0] LVL_IF   = 3'd1;
    localparam logic [2:0] LVL_ID   = 3'd2;
    localparam logic [2:0] LVL_EX   = 3'd3;
    localparam logic [2:0] LVL_MEM  = 3'd4;
    localparam logic [2:0] LVL_EXC  = 3'd5;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between the hazard sources and the pipeline flops.
interface pipe_stall_ctrl_if;
    logic if_stall_req;
    logic id_load_use;
    logic ex_div_req;
    logic mem_stall_req;
    logic exc_flush;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
    logic div_start, div_cancel, div_done, div_busy;

    modport master (
        output if_stall_req, id_load_use, ex_div_req, mem_stall_req, exc_flush,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
        input  div_start, div_cancel, div_done, div_busy
    );

    modport slave (
        input  if_stall_req, id_load_use, ex_div_req, mem_stall_req, exc_flush,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
        output div_start, div_cancel, div_done, div_busy
    );
endinterface

// File: rtl/pipe_stall_ctrl_div_seq.sv
// Divider start/wait/done sequencer: holds EX for 1+DIV_LAT cycles per divide.
module div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_div_req_i,
    input  logic mem_stall_req_i,
    input  logic exc_flush_i,
    output logic div_start_o,
    output logic div_busy_o,
    output logic div_done_o,
    output logic div_cancel_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state, countdown and handshake outputs; a flush overrides everything
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_start_o  = 1'b0;
        div_busy_o   = 1'b0;
        div_done_o   = 1'b0;
        div_cancel_o = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                // A MEM stall defers the start; the request is still there afterwards
                if (ex_div_req_i && !mem_stall_req_i && !exc_flush_i) begin
                    div_start_o = 1'b1;
                    div_busy_o  = 1'b1;
                    cnt_d       = CNT_W'(DIV_LAT - 1);
                    state_d     = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                // Countdown keeps running under a MEM stall: the divider is independent
                div_busy_o = 1'b1;
                if (cnt_q == '0) state_d = DIV_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DIV_DONE: begin
                // Result held until EX can actually advance; no retrigger here
                div_done_o = 1'b1;
                if (!mem_stall_req_i) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (exc_flush_i) begin
            div_busy_o   = 1'b0;
            div_done_o   = 1'b0;
            div_cancel_o = (state_q != DIV_IDLE);
            state_d      = DIV_IDLE;
            cnt_d        = '0;
        end
        // Reset silences the handshake; the divider resets itself
        if (rst) begin
            div_start_o  = 1'b0;
            div_busy_o   = 1'b0;
            div_done_o   = 1'b0;
            div_cancel_o = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: priority encode the stall sources and
// decode per-register load enables and bubble clears.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stall_ctrl_if.slave bus
);

    logic       div_busy;
    logic [2:0] lvl;
    logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [3:0] clr;  // {if_id, id_ex, ex_mem, mem_wb}

    div_seq #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_div (
        .clk             (clk),
        .rst             (rst),
        .ex_div_req_i    (bus.ex_div_req),
        .mem_stall_req_i (bus.mem_stall_req),
        .exc_flush_i     (bus.exc_flush),
        .div_start_o     (bus.div_start),
        .div_busy_o      (div_busy),
        .div_done_o      (bus.div_done),
        .div_cancel_o    (bus.div_cancel)
    );

    assign bus.div_busy = div_busy;

    // Deepest asserted source wins
    always_comb begin
        lvl = LVL_NONE;
        if      (bus.exc_flush)     lvl = LVL_EXC;
        else if (bus.mem_stall_req) lvl = LVL_MEM;
        else if (div_busy)          lvl = LVL_EX;
        else if (bus.id_load_use)   lvl = LVL_ID;
        else if (bus.if_stall_req)  lvl = LVL_IF;
    end

    // Stages upstream of the stall hold, the stalled stage's output register
    // takes a bubble, everything downstream advances
    always_comb begin
        en  = 5'b11111;
        clr = 4'b0000;
        case (lvl)
            LVL_EXC: clr = 4'b1111;
            LVL_MEM: begin en = 5'b00001; clr = 4'b0001; end
            LVL_EX:  begin en = 5'b00011; clr = 4'b0010; end
            LVL_ID:  begin en = 5'b00111; clr = 4'b0100; end
            LVL_IF:  begin en = 5'b01111; clr = 4'b1000; end
            default: ;
        endcase
        if (rst) begin
            en  = '0;
            clr = '0;
        end
    end

    assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en} = en;
    assign {bus.if_id_clr, bus.id_ex_clr, bus.ex_mem_clr, bus.mem_wb_clr}        = clr;

endmodule
